// File: rtl/mem_wb_stage.sv
// Memory/writeback stage: captures the execute result, runs loads/stores over a
// valid/ready data port and produces writeback plus two forwarding values.
// Optional stall-cycle counter enabled by defining MEM_WB_PERF_EN.
module mem_wb_stage #(
    parameter int          XLEN           = 32,
    parameter logic [31:0] RESET_PC_PLUS4 = 32'h0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_valid,
    input  logic [31:0]     ex_inst,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_alu,
    input  logic [XLEN-1:0] ex_store_data,
    output logic            stall,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [3:0]      mem_we,
    input  logic            mem_rsp_valid,
    input  logic [XLEN-1:0] mem_rsp_data,
    output logic            wb_valid,
    output logic            wb_we,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic [XLEN-1:0] fwd_data,
    output logic [XLEN-1:0] fwd_data_ff1,
    output logic            misaligned
`ifdef MEM_WB_PERF_EN
    ,
    output logic [31:0]     perf_stall_cycles
`endif
);

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
    state_t state;

    // M register: only the fields the memory phase still needs after capture.
    logic            m_is_store;
    logic [4:0]      m_rd;
    logic [2:0]      m_funct3;
    logic [XLEN-1:0] m_alu;
    logic [XLEN-1:0] m_store_data;

    logic [6:0]      ex_opcode;
    logic [4:0]      ex_rd;
    logic [2:0]      ex_funct3;
    logic            ex_is_load, ex_is_store, ex_is_mem, ex_misaligned;
    logic [XLEN-1:0] ex_result;
    logic            unused_inst_bits;

    assign ex_opcode   = ex_inst[6:0];
    assign ex_rd       = ex_inst[11:7];
    assign ex_funct3   = ex_inst[14:12];
    assign ex_is_load  = (ex_opcode == OP_LOAD);
    assign ex_is_store = (ex_opcode == OP_STORE);
    assign ex_is_mem   = ex_is_load | ex_is_store;
    assign ex_result   = (ex_opcode == OP_JAL || ex_opcode == OP_JALR) ? ex_pc + 32'd4 : ex_alu;
    assign unused_inst_bits = ^ex_inst[31:15];

    // funct3[1:0]: 00 byte, 01 half, anything else is a word access.
    always_comb begin
        unique case (ex_funct3[1:0])
            2'b00:   ex_misaligned = 1'b0;
            2'b01:   ex_misaligned = ex_alu[0];
            default: ex_misaligned = (ex_alu[1:0] != 2'b00);
        endcase
    end

    // Request side is driven straight from M so it holds stable until accepted.
    logic [1:0] m_off;
    assign m_off         = m_alu[1:0];
    assign stall         = (state != IDLE);
    assign mem_req_valid = (state == REQ);
    assign mem_addr      = {m_alu[31:2], 2'b00};

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        mem_wdata = m_store_data;
        mem_we    = 4'b0000;
        unique case (m_funct3[1:0])
            2'b00:   mem_wdata = {4{m_store_data[7:0]}};
            2'b01:   mem_wdata = {2{m_store_data[15:0]}};
            default: mem_wdata = m_store_data;
        endcase
        if (state == REQ && m_is_store) begin
            unique case (m_funct3[1:0])
                2'b00:   mem_we = 4'b0001 << m_off;
                2'b01:   mem_we = 4'b0011 << m_off;
                default: mem_we = 4'b1111;
            endcase
        end
    end

    logic [XLEN-1:0] rsp_shifted, load_data;
    assign rsp_shifted = mem_rsp_data >> {m_off, 3'b000};

    always_comb begin
        unique case (m_funct3)
            3'b000:  load_data = {{24{rsp_shifted[7]}}, rsp_shifted[7:0]};
            3'b001:  load_data = {{16{rsp_shifted[15]}}, rsp_shifted[15:0]};
            3'b100:  load_data = {24'h0, rsp_shifted[7:0]};
            3'b101:  load_data = {16'h0, rsp_shifted[15:0]};
            default: load_data = mem_rsp_data;
        endcase
    end

    // Retire selection for this cycle, shared by all three retire paths.
    logic            ret_valid, ret_we;
    logic [4:0]      ret_rd;
    logic [XLEN-1:0] ret_data;

    always_comb begin
        ret_valid = 1'b0;
        ret_we    = 1'b0;
        ret_rd    = ex_rd;
        ret_data  = ex_result;
        unique case (state)
            IDLE: if (ex_valid && (!ex_is_mem || ex_misaligned)) begin
                ret_valid = 1'b1;
                ret_we    = !ex_is_mem && (ex_rd != 5'd0);
            end
            REQ: if (mem_req_ready && m_is_store) begin
                ret_valid = 1'b1;
                ret_rd    = m_rd;
            end
            WAIT: if (mem_rsp_valid) begin
                ret_valid = 1'b1;
                ret_we    = (m_rd != 5'd0);
                ret_rd    = m_rd;
                ret_data  = load_data;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            // NOTE: the M register is reset too, so an aborted access leaves no stale state behind.
            state        <= IDLE;
            m_is_store   <= 1'b0;
            m_rd         <= 5'd0;
            m_funct3     <= 3'd0;
            m_alu        <= '0;
            m_store_data <= '0;
            wb_valid     <= 1'b0;
            wb_we        <= 1'b0;
            wb_rd        <= 5'd0;
            wb_data      <= RESET_PC_PLUS4;
            fwd_data_ff1 <= RESET_PC_PLUS4;
            misaligned   <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            wb_valid   <= ret_valid;
            wb_we      <= ret_valid & ret_we;
            misaligned <= 1'b0;
            if (ret_valid) wb_rd <= ret_rd;
            if (ret_valid && ret_we) begin
                fwd_data_ff1 <= wb_data;
                wb_data      <= ret_data;
            end
            unique case (state)
                IDLE: begin
                    m_is_store   <= ex_is_store;
                    m_rd         <= ex_rd;
                    m_funct3     <= ex_funct3;
                    m_alu        <= ex_alu;
                    m_store_data <= ex_store_data;
                    if (ex_valid && ex_is_mem) begin
                        if (ex_misaligned) misaligned <= 1'b1;
                        else               state      <= REQ;
                    end
                end
                REQ:     if (mem_req_ready) state <= m_is_store ? IDLE : WAIT;
                WAIT:    if (mem_rsp_valid) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign fwd_data = wb_data;

`ifdef MEM_WB_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst)       perf_stall_cycles <= 32'd0;
        else if (stall) perf_stall_cycles <= perf_stall_cycles + 32'd1;
    end
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed-vector bench for mem_wb_stage: ALU, load, store, misaligned,
// back-to-back forwarding and reset-during-access scenarios.
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic [31:0] ex_inst, ex_pc, ex_alu, ex_store_data;
    logic        stall, mem_req_valid, mem_req_ready;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_we;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        wb_valid, wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data, fwd_data, fwd_data_ff1;
    logic        misaligned;
`ifdef MEM_WB_PERF_EN
    logic [31:0] perf_stall_cycles;
`endif

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    mem_wb_stage dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_inst(ex_inst), .ex_pc(ex_pc),
        .ex_alu(ex_alu), .ex_store_data(ex_store_data), .stall(stall),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rsp_valid(mem_rsp_valid),
        .mem_rsp_data(mem_rsp_data), .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd),
        .wb_data(wb_data), .fwd_data(fwd_data), .fwd_data_ff1(fwd_data_ff1),
        .misaligned(misaligned)
`ifdef MEM_WB_PERF_EN
        , .perf_stall_cycles(perf_stall_cycles)
`endif
    );

    // Inputs change and outputs are sampled 1ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] inst, input logic [31:0] pc,
                         input logic [31:0] alu, input logic [31:0] sdata);
        ex_valid = 1'b1; ex_inst = inst; ex_pc = pc; ex_alu = alu; ex_store_data = sdata;
        tick();
        ex_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick(); tick();
        total++; if (stall !== 1'b0) $display("FAIL reset_stall got=%b exp=0", stall); else passed++;
        total++; if (mem_req_valid !== 1'b0) $display("FAIL reset_req got=%b exp=0", mem_req_valid); else passed++;
        total++; if (mem_we !== 4'b0) $display("FAIL reset_we got=%b exp=0000", mem_we); else passed++;
        total++; if ({wb_valid, wb_we, misaligned} !== 3'b000) $display("FAIL reset_pulses got=%b exp=000", {wb_valid, wb_we, misaligned}); else passed++;
        total++; if (wb_rd !== 5'd0) $display("FAIL reset_rd got=%0d exp=0", wb_rd); else passed++;
        total++; if ({wb_data, fwd_data, fwd_data_ff1} !== 96'h0) $display("FAIL reset_data got=%h exp=0", {wb_data, fwd_data, fwd_data_ff1}); else passed++;
        rst = 1'b1;
        tick();
    endtask

    task automatic test_alu();
        ex_valid = 1'b1; ex_inst = 32'h0000_0293; ex_pc = 32'h0; ex_alu = 32'h1234; ex_store_data = 32'h0;
        #1;
        total++; if (stall !== 1'b0) $display("FAIL alu_stall_pre got=%b exp=0", stall); else passed++;
        tick();
        ex_valid = 1'b0;
        total++; if ({wb_valid, wb_we} !== 2'b11) $display("FAIL alu_wb got=%b exp=11", {wb_valid, wb_we}); else passed++;
        total++; if (wb_rd !== 5'd5) $display("FAIL alu_rd got=%0d exp=5", wb_rd); else passed++;
        total++; if (wb_data !== 32'h1234) $display("FAIL alu_data got=%h exp=00001234", wb_data); else passed++;
        total++; if (stall !== 1'b0) $display("FAIL alu_stall got=%b exp=0", stall); else passed++;
        tick();
        total++; if (wb_valid !== 1'b0) $display("FAIL alu_pulse got=%b exp=0", wb_valid); else passed++;
    endtask

    task automatic test_load_byte();
        int  stall_cnt = 0;
        bit  got = 1'b0;
        mem_req_ready = 1'b0;
        issue(32'h0000_0303, 32'h8, 32'h103, 32'h0);
        total++; if ({mem_req_valid, stall} !== 2'b11) $display("FAIL lb_req got=%b exp=11", {mem_req_valid, stall}); else passed++;
        total++; if (mem_addr !== 32'h100) $display("FAIL lb_addr got=%h exp=00000100", mem_addr); else passed++;
        total++; if (mem_we !== 4'b0000) $display("FAIL lb_we got=%b exp=0000", mem_we); else passed++;
        for (int i = 0; i < 20 && !got; i++) begin
            mem_req_ready = (i == 2);
            mem_rsp_valid = (i == 3);
            mem_rsp_data  = 32'h80FF_0000;
            if (stall) stall_cnt++;
            tick();
            if (wb_valid) got = 1'b1;
        end
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
        total++; if (got !== 1'b1) $display("FAIL lb_timeout got=%b exp=1", got); else passed++;
        total++; if (stall_cnt != 4) $display("FAIL lb_stall_cycles got=%0d exp=4", stall_cnt); else passed++;
        total++; if (wb_data !== 32'hFFFF_FF80) $display("FAIL lb_data got=%h exp=ffffff80", wb_data); else passed++;
        total++; if ({wb_we, wb_rd} !== {1'b1, 5'd6}) $display("FAIL lb_rd got=%b/%0d exp=1/6", wb_we, wb_rd); else passed++;
        total++; if (fwd_data_ff1 !== 32'h1234) $display("FAIL lb_ff1 got=%h exp=00001234", fwd_data_ff1); else passed++;
        total++; if (stall !== 1'b0) $display("FAIL lb_stall_end got=%b exp=0", stall); else passed++;
    endtask

    task automatic test_store_half();
        mem_req_ready = 1'b0;
        issue(32'h0000_1023, 32'hC, 32'h22, 32'h0000_ABCD);
        total++; if ({mem_req_valid, stall} !== 2'b11) $display("FAIL sh_req got=%b exp=11", {mem_req_valid, stall}); else passed++;
        total++; if (mem_addr !== 32'h20) $display("FAIL sh_addr got=%h exp=00000020", mem_addr); else passed++;
        total++; if (mem_we !== 4'b1100) $display("FAIL sh_we got=%b exp=1100", mem_we); else passed++;
        total++; if (mem_wdata !== 32'hABCD_ABCD) $display("FAIL sh_wdata got=%h exp=abcdabcd", mem_wdata); else passed++;
        tick();
        total++; if ({mem_req_valid, mem_we, mem_addr} !== {1'b1, 4'b1100, 32'h20}) $display("FAIL sh_hold got=%b/%b/%h exp=1/1100/00000020", mem_req_valid, mem_we, mem_addr); else passed++;
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        total++; if ({wb_valid, wb_we} !== 2'b10) $display("FAIL sh_wb got=%b exp=10", {wb_valid, wb_we}); else passed++;
        total++; if ({stall, mem_req_valid, mem_we} !== 6'b0) $display("FAIL sh_idle got=%b exp=000000", {stall, mem_req_valid, mem_we}); else passed++;
        total++; if (wb_data !== 32'hFFFF_FF80) $display("FAIL sh_hold_data got=%h exp=ffffff80", wb_data); else passed++;
    endtask

    task automatic test_misaligned();
        issue(32'h0000_2383, 32'h10, 32'h6, 32'h0);
        total++; if ({misaligned, wb_valid, wb_we} !== 3'b110) $display("FAIL mis_pulse got=%b exp=110", {misaligned, wb_valid, wb_we}); else passed++;
        total++; if ({mem_req_valid, stall} !== 2'b00) $display("FAIL mis_noreq got=%b exp=00", {mem_req_valid, stall}); else passed++;
        tick();
        total++; if ({misaligned, wb_valid, mem_req_valid, stall} !== 4'b0) $display("FAIL mis_after got=%b exp=0000", {misaligned, wb_valid, mem_req_valid, stall}); else passed++;
    endtask

    task automatic test_back_to_back();
        ex_valid = 1'b1; ex_inst = 32'h0000_00EF; ex_pc = 32'h40; ex_alu = 32'h999; ex_store_data = 32'h0;
        tick();
        total++; if (wb_data !== 32'h44) $display("FAIL jal_data got=%h exp=00000044", wb_data); else passed++;
        ex_inst = 32'h0000_0133; ex_pc = 32'h44; ex_alu = 32'h7;
        tick();
        ex_valid = 1'b0;
        total++; if ({wb_data, fwd_data} !== {32'h7, 32'h7}) $display("FAIL b2b_data got=%h/%h exp=00000007", wb_data, fwd_data); else passed++;
        total++; if (fwd_data_ff1 !== 32'h44) $display("FAIL b2b_ff1 got=%h exp=00000044", fwd_data_ff1); else passed++;
        total++; if ({wb_valid, wb_rd} !== {1'b1, 5'd2}) $display("FAIL b2b_rd got=%b/%0d exp=1/2", wb_valid, wb_rd); else passed++;
    endtask

    task automatic test_reset_mid();
        mem_req_ready = 1'b1;
        issue(32'h0000_2403, 32'h50, 32'h100, 32'h0);
        tick();
        mem_req_ready = 1'b0;
        total++; if ({stall, mem_req_valid} !== 2'b10) $display("FAIL rmid_wait got=%b exp=10", {stall, mem_req_valid}); else passed++;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        total++; if ({stall, wb_valid, wb_we, misaligned, mem_req_valid} !== 5'b0) $display("FAIL rmid_reset got=%b exp=00000", {stall, wb_valid, wb_we, misaligned, mem_req_valid}); else passed++;
        total++; if ({wb_data, fwd_data_ff1, wb_rd} !== 69'h0) $display("FAIL rmid_data got=%h/%h/%0d exp=0", wb_data, fwd_data_ff1, wb_rd); else passed++;
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'hDEAD_BEEF;
        tick();
        mem_rsp_valid = 1'b0;
        total++; if ({wb_valid, stall} !== 2'b00) $display("FAIL rmid_rsp_ignored got=%b exp=00", {wb_valid, stall}); else passed++;
        total++; if (wb_data !== 32'h0) $display("FAIL rmid_rsp_data got=%h exp=00000000", wb_data); else passed++;
    endtask

    initial begin
        rst = 1'b0; ex_valid = 1'b0; ex_inst = '0; ex_pc = '0; ex_alu = '0; ex_store_data = '0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
        test_reset();
        test_alu();
        test_load_byte();
        test_store_half();
        test_misaligned();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
